// File: rtl/esm_issue_window.sv
// Multi-issue instruction window: buffers decoded instructions, tracks register hazards with an
// age matrix, issues up to ISSUE_W ready entries oldest-first. Define ESM_WAR_WAW_EN to add WAR/WAW blocking.
module esm_issue_window #(
  parameter int INSTR_W  = 32,
  parameter int REGNUM   = 32,
  parameter int BS       = 16,
  parameter int ISSUE_W  = 2,
  localparam int BS_BITS = $clog2(BS)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [INSTR_W-1:0]         in_instr_i,
  input  logic                       in_alusrc_i,
  input  logic                       in_regwrite_i,
  input  logic                       issue_en_i,
  output logic [ISSUE_W-1:0]         issue_valid_o,
  output logic [ISSUE_W*BS_BITS-1:0] issue_index_o,
  output logic [ISSUE_W*INSTR_W-1:0] issue_instr_o,
  input  logic                       complete_valid_i,
  input  logic [BS_BITS-1:0]         complete_index_i,
  output logic [BS_BITS:0]           occupancy_o
);

  localparam int REG_W = $clog2(REGNUM);

  logic [BS-1:0]                   valid_q, valid_d;
  logic [BS-1:0]                   issued_q, issued_d;
  logic [BS-1:0]                   alusrc_q, regwrite_q;
  logic [INSTR_W-1:0]              instr_q [BS];
  // age_q[i][j] set means entry j is older than entry i
  logic [BS-1:0][BS-1:0]           age_q;
  logic [BS_BITS:0]                occupancy_q, occupancy_d;
  logic [ISSUE_W-1:0]              issue_valid_q;
  logic [ISSUE_W-1:0][BS_BITS-1:0] issue_index_q;
  logic [ISSUE_W-1:0][INSTR_W-1:0] issue_instr_q;

  logic [REG_W-1:0] rd_w  [BS];
  logic [REG_W-1:0] rs1_w [BS];
  logic [REG_W-1:0] rs2_w [BS];
  logic [BS-1:0]    blocked_w, ready_w;

  for (genvar gi = 0; gi < BS; gi++) begin : g_field
    assign rd_w[gi]  = instr_q[gi][7 +: REG_W];
    assign rs1_w[gi] = instr_q[gi][15 +: REG_W];
    assign rs2_w[gi] = instr_q[gi][20 +: REG_W];
  end

  for (genvar gi = 0; gi < BS; gi++) begin : g_row
    logic [BS-1:0] dep_row;
    for (genvar gj = 0; gj < BS; gj++) begin : g_col
      logic raw, haz;
      assign raw = regwrite_q[gj] && (rd_w[gj] != '0) &&
                   ((rd_w[gj] == rs1_w[gi]) || (!alusrc_q[gi] && (rd_w[gj] == rs2_w[gi])));
`ifdef ESM_WAR_WAW_EN
      logic waw, war;
      assign waw = regwrite_q[gj] && regwrite_q[gi] && (rd_w[gj] != '0) && (rd_w[gi] == rd_w[gj]);
      // WAR only matters until the older reader has left the window for execution
      assign war = regwrite_q[gi] && (rd_w[gi] != '0) && !issued_q[gj] &&
                   ((rd_w[gi] == rs1_w[gj]) || (!alusrc_q[gj] && (rd_w[gi] == rs2_w[gj])));
      assign haz = raw | waw | war;
`else
      assign haz = raw;
`endif
      assign dep_row[gj] = age_q[gi][gj] & valid_q[gj] & haz;
    end
    assign blocked_w[gi] = |dep_row;
  end

  assign ready_w = valid_q & ~issued_q & ~blocked_w;

  logic [BS-1:0]                   pick_mask_w;
  logic [ISSUE_W-1:0]              pick_found_w;
  logic [ISSUE_W-1:0][BS_BITS-1:0] pick_idx_w;

  // Each lane takes the ready entry with no older ready entry still unpicked
  always_comb begin
    logic [BS-1:0] remain;
    remain       = ready_w & {BS{issue_en_i}};
    pick_mask_w  = '0;
    pick_found_w = '0;
    pick_idx_w   = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      for (int i = 0; i < BS; i++) begin
        if (remain[i] && ((age_q[i] & remain) == '0)) begin
          pick_found_w[k] = 1'b1;
          pick_idx_w[k]   = BS_BITS'(i);
        end
      end
      if (pick_found_w[k]) begin
        remain[pick_idx_w[k]]      = 1'b0;
        pick_mask_w[pick_idx_w[k]] = 1'b1;
      end
    end
  end

  logic [BS_BITS-1:0] alloc_idx_w;
  logic               full_w, accept_w, cmp_ok_w;

  always_comb begin
    alloc_idx_w = '0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx_w = BS_BITS'(i);
    end
  end

  assign full_w     = (occupancy_q == (BS_BITS+1)'(BS));
  assign in_ready_o = rst_ni & ~full_w;
  assign accept_w   = in_valid_i & in_ready_o;
  assign cmp_ok_w   = complete_valid_i & valid_q[complete_index_i] & issued_q[complete_index_i];

  always_comb begin
    valid_d  = valid_q;
    issued_d = issued_q | pick_mask_w;
    if (cmp_ok_w) begin
      valid_d[complete_index_i]  = 1'b0;
      issued_d[complete_index_i] = 1'b0;
    end
    // allocation only ever targets a slot that was already free before this edge
    if (accept_w) begin
      valid_d[alloc_idx_w]  = 1'b1;
      issued_d[alloc_idx_w] = 1'b0;
    end
    occupancy_d = occupancy_q + (BS_BITS+1)'(accept_w) - (BS_BITS+1)'(cmp_ok_w);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q       <= '0;
      issued_q      <= '0;
      alusrc_q      <= '0;
      regwrite_q    <= '0;
      age_q         <= '0;
      occupancy_q   <= '0;
      issue_valid_q <= '0;
      issue_index_q <= '0;
      issue_instr_q <= '0;
      for (int i = 0; i < BS; i++) instr_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      issued_q    <= issued_d;
      occupancy_q <= occupancy_d;
      if (accept_w) begin
        instr_q[alloc_idx_w]    <= in_instr_i;
        alusrc_q[alloc_idx_w]   <= in_alusrc_i;
        regwrite_q[alloc_idx_w] <= in_regwrite_i;
        for (int r = 0; r < BS; r++) age_q[r][alloc_idx_w] <= 1'b0;
        age_q[alloc_idx_w] <= valid_q;
      end
      for (int k = 0; k < ISSUE_W; k++) begin
        issue_valid_q[k] <= pick_found_w[k];
        if (pick_found_w[k]) begin
          issue_index_q[k] <= pick_idx_w[k];
          issue_instr_q[k] <= instr_q[pick_idx_w[k]];
        end
      end
    end
  end

  assign issue_valid_o = issue_valid_q;
  assign issue_index_o = issue_index_q;
  assign issue_instr_o = issue_instr_q;
  assign occupancy_o   = occupancy_q;

endmodule

// File: tb/tb_esm_issue_window.sv
// Scoreboard bench for esm_issue_window: an age-ordered queue model predicts every cycle's
// issue lanes, occupancy and in_ready; a negedge monitor pops and compares.
module tb_esm_issue_window;

  localparam int INSTR_W = 32;
  localparam int BS      = 16;
  localparam int BS_BITS = 4;
  localparam int ISSUE_W = 2;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       in_valid, in_ready, in_alusrc, in_regwrite, issue_en;
  logic [INSTR_W-1:0]         in_instr;
  logic [ISSUE_W-1:0]         issue_valid;
  logic [ISSUE_W*BS_BITS-1:0] issue_index;
  logic [ISSUE_W*INSTR_W-1:0] issue_instr;
  logic                       complete_valid;
  logic [BS_BITS-1:0]         complete_index;
  logic [BS_BITS:0]           occupancy;

  esm_issue_window #(.INSTR_W(INSTR_W), .REGNUM(32), .BS(BS), .ISSUE_W(ISSUE_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_instr_i(in_instr),
    .in_alusrc_i(in_alusrc), .in_regwrite_i(in_regwrite), .issue_en_i(issue_en),
    .issue_valid_o(issue_valid), .issue_index_o(issue_index), .issue_instr_o(issue_instr),
    .complete_valid_i(complete_valid), .complete_index_i(complete_index),
    .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BS_BITS-1:0] slot;
    logic [31:0]        ins;
    logic               alusrc;
    logic               regwrite;
    logic               issued;
  } ent_t;

  typedef struct packed {
    logic [ISSUE_W-1:0]              vld;
    logic [ISSUE_W-1:0][BS_BITS-1:0] idx;
    logic [ISSUE_W-1:0][31:0]        ins;
    logic [BS_BITS:0]                occ;
    logic                            rdy;
  } exp_t;

  ent_t mq[$];            // model window, oldest at front
  exp_t exp_q[$];
  logic [ISSUE_W-1:0][BS_BITS-1:0] last_idx;
  logic [ISSUE_W-1:0][31:0]        last_ins;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  function automatic logic [31:0] make_r(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] make_i(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'h13};
  endfunction

  // Does older entry o hold back younger entry y?
  function automatic bit haz(ent_t o, ent_t y);
    logic [4:0] rd_o, rs1_o, rs2_o, rd_y, rs1_y, rs2_y;
    bit r;
    rd_o = o.ins[11:7]; rs1_o = o.ins[19:15]; rs2_o = o.ins[24:20];
    rd_y = y.ins[11:7]; rs1_y = y.ins[19:15]; rs2_y = y.ins[24:20];
    r = o.regwrite && rd_o != 0 && (rd_o == rs1_y || (!y.alusrc && rd_o == rs2_y));
`ifdef ESM_WAR_WAW_EN
    if (o.regwrite && y.regwrite && rd_o != 0 && rd_o == rd_y) r = 1;
    if (y.regwrite && rd_y != 0 && !o.issued && (rd_y == rs1_o || (!o.alusrc && rd_y == rs2_o))) r = 1;
`endif
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("issue_valid", 64'(issue_valid), 64'(e.vld));
      for (int k = 0; k < ISSUE_W; k++) begin
        chk("issue_index", 64'(issue_index[k*BS_BITS +: BS_BITS]), 64'(e.idx[k]));
        chk("issue_instr", 64'(issue_instr[k*INSTR_W +: INSTR_W]), 64'(e.ins[k]));
      end
      chk("occupancy", 64'(occupancy), 64'(e.occ));
      chk("in_ready", 64'(in_ready), 64'(e.rdy));
    end
  end

  // Advance model and DUT by one clock with the currently driven inputs
  task automatic step();
    exp_t e;
    e = '0;
    if (!rst_n) begin
      mq.delete();
      last_idx = '0;
      last_ins = '0;
    end else begin
      int picks[$];
      int cpos, aslot;
      bit used [BS];
      bit room;
      room = mq.size() < BS;
      if (issue_en) begin
        for (int p = 0; p < mq.size(); p++) begin
          bit blk = 0;
          for (int q = 0; q < p; q++) if (haz(mq[q], mq[p])) blk = 1;
          if (!mq[p].issued && !blk && picks.size() < ISSUE_W) picks.push_back(p);
        end
      end
      cpos = -1;
      if (complete_valid)
        for (int p = 0; p < mq.size(); p++)
          if (mq[p].slot == complete_index && mq[p].issued) cpos = p;
      aslot = -1;
      if (in_valid && room) begin
        for (int s = 0; s < BS; s++) used[s] = 0;
        for (int p = 0; p < mq.size(); p++) used[mq[p].slot] = 1;
        for (int s = BS - 1; s >= 0; s--) if (!used[s]) aslot = s;
      end
      for (int k = 0; k < picks.size(); k++) begin
        e.vld[k]    = 1'b1;
        last_idx[k] = mq[picks[k]].slot;
        last_ins[k] = mq[picks[k]].ins;
        mq[picks[k]].issued = 1'b1;
      end
      if (cpos >= 0) mq.delete(cpos);
      if (aslot >= 0) mq.push_back('{BS_BITS'(aslot), in_instr, in_alusrc, in_regwrite, 1'b0});
      if (picks.size() != 0 || cpos >= 0 || aslot >= 0)
        $display("cycle %0d: accept_slot=%0d complete_pos=%0d issue_lanes=%b lane0_slot=%0d lane1_slot=%0d occ=%0d",
                 cyc, aslot, cpos, e.vld, last_idx[0], last_idx[1], mq.size());
    end
    e.idx = last_idx;
    e.ins = last_ins;
    e.occ = (BS_BITS+1)'(mq.size());
    e.rdy = rst_n && (mq.size() < BS);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(logic [31:0] ins, logic alusrc, logic rw);
    in_valid = 1; in_instr = ins; in_alusrc = alusrc; in_regwrite = rw;
    step();
    in_valid = 0;
  endtask

  task automatic complete(int slot);
    complete_valid = 1; complete_index = BS_BITS'(slot);
    step();
    complete_valid = 0;
  endtask

  task automatic complete_all();
    for (int it = 0; it < 200 && mq.size() != 0; it++) begin
      int s = -1;
      for (int p = 0; p < mq.size(); p++) if (mq[p].issued && s < 0) s = mq[p].slot;
      if (s >= 0) complete(s); else step();
    end
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_instr = '0; in_alusrc = 0; in_regwrite = 0;
    issue_en = 1; complete_valid = 0; complete_index = '0;
    idle(2);
    rst_n = 1;
    idle(1);

    // dependent pair: addi x4 waits on add x3
    push(32'h002081B3, 0, 1);
    push(32'h00118213, 1, 1);
    idle(3);
    complete(0);
    idle(3);
    complete_all();

    // four independent ops issued two per cycle
    issue_en = 0;
    for (int i = 0; i < 4; i++) push(make_r(5 + i, 1, 2), 0, 1);
    issue_en = 1;
    idle(3);
    complete_all();

    // fill to capacity, try an extra push, then reuse slot 7
    for (int i = 0; i < BS; i++) push(make_i(10 + i, 1, i), 1, 1);
    push(make_i(27, 1, 0), 1, 1);
    idle(3);
    complete(7);
    push(make_i(26, 1, 5), 1, 1);
    idle(3);
    complete_all();

    // completions of an empty slot and of an unissued slot are ignored
    complete(5);
    issue_en = 0;
    push(make_r(6, 1, 2), 0, 1);
    complete(0);
    issue_en = 1;
    idle(2);
    complete_all();

    // x0 never creates a hazard; two writers of x9
    issue_en = 0;
    push(make_r(0, 1, 2), 0, 1);
    push(make_r(5, 0, 0), 0, 1);
    issue_en = 1;
    idle(2);
    complete_all();
    issue_en = 0;
    push(make_i(9, 1, 1), 1, 1);
    push(make_i(9, 2, 1), 1, 1);
    issue_en = 1;
    idle(2);
    complete_all();
    idle(2);

    // reset mid-stream with five entries buffered
    issue_en = 0;
    for (int i = 0; i < 5; i++) push(make_r(3 + i, 1, 2), 0, 1);
    issue_en = 1;
    in_valid = 1; in_instr = make_r(12, 3, 4); in_alusrc = 0; in_regwrite = 1;
    rst_n = 0;
    idle(2);
    rst_n = 1;
    in_valid = 0;
    idle(1);
    push(make_r(12, 3, 4), 0, 1);
    idle(2);
    complete_all();

    // randomized traffic with small register range to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      int r = $urandom_range(0, 99);
      in_valid    = ($urandom_range(0, 99) < 60);
      in_alusrc   = $urandom_range(0, 1);
      in_regwrite = ($urandom_range(0, 99) < 85);
      in_instr    = in_alusrc ? make_i($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4095))
                              : make_r($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      issue_en    = ($urandom_range(0, 99) < 80);
      complete_valid = 0;
      if (r < 45) begin
        int cand[$];
        for (int p = 0; p < mq.size(); p++) if (mq[p].issued) cand.push_back(mq[p].slot);
        if (cand.size() != 0) begin
          complete_valid = 1;
          complete_index = BS_BITS'(cand[$urandom_range(0, cand.size() - 1)]);
        end
      end else if (r < 55) begin
        complete_valid = 1;
        complete_index = BS_BITS'($urandom_range(0, BS - 1));
      end
      step();
    end
    in_valid = 0; complete_valid = 0; issue_en = 1;
    complete_all();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
